// File: rtl/cube_pkg.sv
// Shared constants, scan FSM states and voxel indexing for the 8x8x8 LED cube driver.
package cube_pkg;

    localparam int CUBE_DIM   = 8;
    localparam int LAYER_BITS = CUBE_DIM * CUBE_DIM;
    localparam int FRAME_BITS = LAYER_BITS * CUBE_DIM;

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } scan_state_t;

    function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                        input int unsigned z);
        return z * LAYER_BITS + y * CUBE_DIM + x;
    endfunction

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cube_shift_tx.sv
// Serialises one 64-bit layer word MSB first into a 74HC595-style chain.
// Each bit is a CLK_DIV-cycle low phase (data changes on entry) then a CLK_DIV-cycle high phase.
module cube_shift_tx
    import cube_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LAYER_BITS-1:0] word,
    output logic                  done,
    output logic                  ser_clk,
    output logic                  ser_data
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(LAYER_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LAYER_BITS - 1);

    logic                  busy_reg;
    logic [DIV_W-1:0]      div_reg;
    logic [BIT_W-1:0]      bit_reg;
    logic [LAYER_BITS-1:0] shift_reg;
    logic                  ser_clk_reg;
    logic                  ser_data_reg;
    logic                  phase_end;

    assign phase_end = busy_reg && (div_reg == DIV_LAST);
    // Asserted during the final high-phase cycle so the caller leaves SHIFT on the same edge.
    assign done      = phase_end && ser_clk_reg && (bit_reg == BIT_LAST);
    assign ser_clk   = ser_clk_reg;
    assign ser_data  = ser_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= 1'b0;
            div_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            ser_clk_reg  <= 1'b0;
            ser_data_reg <= 1'b0;
        end else if (start) begin
            busy_reg     <= 1'b1;
            div_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= {word[LAYER_BITS-2:0], 1'b0};
            ser_data_reg <= word[LAYER_BITS-1];
            ser_clk_reg  <= 1'b0;
        end else if (busy_reg) begin
            if (!phase_end) begin
                div_reg <= div_reg + 1'b1;
            end else begin
                div_reg <= '0;
                if (!ser_clk_reg) begin
                    ser_clk_reg <= 1'b1;
                end else begin
                    ser_clk_reg <= 1'b0;
                    if (bit_reg == BIT_LAST) begin
                        busy_reg <= 1'b0;
                    end else begin
                        bit_reg      <= bit_reg + 1'b1;
                        ser_data_reg <= shift_reg[LAYER_BITS-1];
                        shift_reg    <= {shift_reg[LAYER_BITS-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cube_scan_driver.sv
// Double-buffered 8x8x8 LED cube scanner: BLANK -> SHIFT -> LATCH -> DISPLAY per layer,
// swapping in a pending frame only after layer 7 so the display never tears.
module cube_scan_driver
    import cube_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int LAYER_HOLD   = 2048,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] cells,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic [CUBE_DIM-1:0]   layer_en,
    output logic                  ser_data,
    output logic                  ser_clk,
    output logic                  ser_latch,
    output logic                  ser_oe_n,
    output logic                  frame_sync
);

    localparam int HOLD_MAX = (LAYER_HOLD > CLK_DIV) ? LAYER_HOLD : CLK_DIV;
    localparam int CNT_TOP  = (HOLD_MAX > BLANK_CYCLES) ? HOLD_MAX : BLANK_CYCLES;
    localparam int CNT_W    = cnt_width(CNT_TOP);
    localparam int Z_W      = $clog2(CUBE_DIM);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CNT_TOP - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LAYER_HOLD - 1);
    localparam logic [Z_W-1:0]   LAYER_LAST = Z_W'(CUBE_DIM - 1);

    scan_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [Z_W-1:0]        layer_reg;
    logic [FRAME_BITS-1:0] active_reg;
    logic [FRAME_BITS-1:0] pending_reg;
    logic                  frame_ready_reg;
    logic                  frame_sync_reg;
    logic [CUBE_DIM-1:0]   layer_en_reg;
    logic                  ser_latch_reg;
    logic                  ser_oe_n_reg;

    logic                  tx_start;
    logic                  tx_done;
    logic                  layer_done;
    logic                  capture;
    logic                  swap;
    logic [CUBE_DIM-1:0]   layer_onehot;
    logic [LAYER_BITS-1:0] layer_slice [CUBE_DIM];

    generate
        for (genvar gi = 0; gi < CUBE_DIM; gi++) begin : g_slice
            assign layer_slice[gi] = active_reg[gi*LAYER_BITS +: LAYER_BITS];
        end
    endgenerate

    assign layer_onehot = {{(CUBE_DIM-1){1'b0}}, 1'b1} << layer_reg;
    assign capture      = frame_valid && frame_ready_reg;
    // Pending is full exactly when frame_ready is low, so capture and swap never coincide.
    assign swap         = layer_done && (layer_reg == LAYER_LAST) && !frame_ready_reg;

    always_comb begin
        state_next = state_reg;
        tx_start   = 1'b0;
        layer_done = 1'b0;
        case (state_reg)
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = SHIFT;
                    tx_start   = 1'b1;
                end
            end
            SHIFT: begin
                if (tx_done) state_next = LATCH;
            end
            LATCH: begin
                if (cnt_reg == LATCH_LAST) state_next = DISPLAY;
            end
            DISPLAY: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = BLANK;
                    layer_done = 1'b1;
                end
            end
            default: state_next = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BLANK;
            cnt_reg   <= '0;
            layer_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (layer_done) begin
                layer_reg <= (layer_reg == LAYER_LAST) ? '0 : layer_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg      <= '0;
            pending_reg     <= '0;
            frame_ready_reg <= 1'b1;
            frame_sync_reg  <= 1'b0;
        end else begin
            if (capture) begin
                pending_reg     <= cells;
                frame_ready_reg <= 1'b0;
            end else if (swap) begin
                active_reg      <= pending_reg;
                frame_ready_reg <= 1'b1;
            end
            frame_sync_reg <= swap;
        end
    end

    // Drive strobes from the next state so they are glitch-free registers aligned with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_en_reg  <= '0;
            ser_latch_reg <= 1'b0;
            ser_oe_n_reg  <= 1'b1;
        end else begin
            layer_en_reg  <= (state_next == DISPLAY) ? layer_onehot : '0;
            ser_latch_reg <= (state_next == LATCH);
            ser_oe_n_reg  <= (state_next != DISPLAY);
        end
    end

    cube_shift_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_shift_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tx_start),
        .word     (layer_slice[layer_reg]),
        .done     (tx_done),
        .ser_clk  (ser_clk),
        .ser_data (ser_data)
    );

    assign frame_ready = frame_ready_reg;
    assign frame_sync  = frame_sync_reg;
    assign layer_en    = layer_en_reg;
    assign ser_latch   = ser_latch_reg;
    assign ser_oe_n    = ser_oe_n_reg;

endmodule

// File: doc/cube_scan_driver.md
Name: cube_scan_driver

Overview:
- Downstream consumer of the 512-bit Conway cell vector; drives the physical 8x8x8 LED cube.
- Accepts whole frames over a valid/ready handshake and double-buffers them (pending + active).
- Time-multiplexes the 8 layers: shifts each 64-bit layer slice into an external 74HC595-style chain, latches it, enables one layer driver, then advances.
- Swaps in a new frame only at a frame boundary, so the display never tears.

Parameters:
- CLK_DIV, 4: Clk cycles per half-period of Ser_clk; must be >= 1.
- LAYER_HOLD, 2048: Clk cycles each layer stays lit; must be >= 1.
- BLANK_CYCLES, 4: Clk cycles with everything off before each layer shift (ghosting guard); must be >= 1.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Cells  in  512  frame data; bit index = z*64 + y*8 + x.
- Frame_valid  in  1  Cells holds a new frame.
- Frame_ready  out  1  pending buffer is empty; frame accepted when Frame_valid && Frame_ready.
- Layer_en  out  8  one-hot layer enable, active-high; bit z lights layer z.
- Ser_data  out  1  serial column data to the shift-register chain.
- Ser_clk  out  1  shift clock; external chain samples on its rising edge.
- Ser_latch  out  1  storage-register latch pulse.
- Ser_oe_n  out  1  column output enable, active-low.
- Frame_sync  out  1  one-Clk pulse when the active buffer swaps.

Behaviour:
- Reset (async assert, sync release). Outputs: Layer_en=0, Ser_data=0, Ser_clk=0, Ser_latch=0, Ser_oe_n=1, Frame_ready=1, Frame_sync=0. Internal: active buffer=0, pending empty, layer index=0, FSM=BLANK.
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for a Clk edge.
- Handshake:
  - Capture Cells into pending when Frame_valid && Frame_ready.
  - Frame_ready deasserts the cycle after capture and stays low until pending is consumed.
  - While Frame_ready=0, Frame_valid is ignored and Cells may change freely.
- FSM, per layer:
  - BLANK: Layer_en=0, Ser_oe_n=1, for BLANK_CYCLES cycles, then go to SHIFT.
  - SHIFT: 64 bits, active bit (z*64+63) first down to (z*64+0).
    - Each bit: Ser_clk low for CLK_DIV cycles with Ser_data updated on entry to the low phase, then high for CLK_DIV cycles.
    - Ser_clk ends low. SHIFT lasts exactly 128*CLK_DIV cycles.
  - LATCH: Ser_latch=1 for CLK_DIV cycles, then go to DISPLAY.
  - DISPLAY: Ser_oe_n=0 and Layer_en = 1<<z, for LAYER_HOLD cycles. On exit, z = z+1 modulo 8; z=7 wraps to 0.
- Frame boundary (leaving DISPLAY with z=7):
  - If pending is full, copy it to active, mark pending empty, and pulse Frame_sync for 1 cycle.
  - Frame_ready rises the next cycle.
- Simultaneous events:
  - A capture and a swap cannot occur in the same cycle, because Frame_ready=0 whenever pending is full.
  - A frame accepted during layer 7 DISPLAY is shown starting with the next layer 0.
  - If pending is empty at the boundary, the active frame simply repeats.
- Cycles per layer = BLANK_CYCLES + 128*CLK_DIV + CLK_DIV + LAYER_HOLD. With the defaults: 4 + 512 + 4 + 2048 = 2568; frame = 20544 cycles.
- Invariants:
  - Layer_en is never non-zero while Ser_oe_n=1.
  - At most one Layer_en bit is ever high.
- All counters are sized with $clog2 of their maximum value. Counters saturate at their terminal count, are cleared on each state entry, and never wrap silently.

Decomposition:
- Package cube_pkg holds:
  - the constants CUBE_DIM=8, LAYER_BITS=64, FRAME_BITS=512;
  - the FSM state enum (BLANK, SHIFT, LATCH, DISPLAY);
  - the cell index function idx(x,y,z).
- One natural sub-module: cube_shift_tx. It serialises a 64-bit word with CLK_DIV timing, uses a start/done handshake, and owns Ser_clk and Ser_data.
- The top-level FSM, double buffer and layer counter stay in cube_scan_driver.

Test Plan:
1. Reset check: hold Reset=0 for 5 cycles, then release. Expect Layer_en=0, Ser_oe_n=1, Frame_ready=1, and the first Ser_clk rising edge at cycle 4+4=8 after release.
2. Single voxel: CLK_DIV=1, LAYER_HOLD=16; send Cells with only bit 130 set (x=2,y=0,z=2). Expect:
   - the layer-2 serial stream is 61 zeros, a 1, then two zeros;
   - all other layers shift all-zero;
   - Layer_en=8'h04 for exactly 16 cycles.
3. Double buffer: send frame A (all ones), then frame B (all zeros) immediately. Expect:
   - Frame_ready drops after A;
   - B is stalled until the first boundary, where Frame_sync pulses;
   - one full frame shows A, and B is visible only after the second Frame_sync.
4. Tear-free swap: with Frame_valid held high and Cells changing every cycle, check Ser_data for layers 0–7 of each frame against the frame captured at acceptance.
5. Reset mid-SHIFT: assert Reset at bit 30 of layer 5. Expect all outputs at reset values in the same cycle. After release, scanning restarts at layer 0 with an all-zero active frame.
6. Invariant monitor, running throughout all tests: assert one-hot-or-zero Layer_en, Layer_en==0 whenever Ser_oe_n==1, and a per-layer cycle count of exactly 2568 with default parameters.
